mc_main_ctrl: RTL and testbench
===============================

// Module: mc_main_ctrl
// PURPOSE
//  Multi-cycle MIPS main control FSM, directly upstream of alu_dec: decodes op, sequences
//  fetch/decode/execute/memory/writeback, drives datapath enables and the 2-bit aluop that
//  alu_dec expands with funct. Waits on memory via mem_ready. Supports lw, sw, R-type, beq, addi, j.
// PARAMETERS
//  WAIT_EN   1  1: FETCH/MEMRD/MEMWR hold until mem_ready; 0: mem_ready ignored (1-cycle memory)
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  reset, asynchronous, active-high
//  op         in   6  instr[31:26] from instruction register
//  zero       in   1  ALU zero flag (valid in BEQEX)
//  mem_ready  in   1  memory access completes this cycle
//  aluop      out  2  to alu_dec: 00 add, 01 sub, 10 use funct
//  alusrca    out  1  0 PC, 1 regA
//  alusrcb    out  2  00 regB, 01 const 4, 10 signimm, 11 signimm<<2
//  pcsrc      out  2  00 ALU result, 01 ALUOut, 10 jump target
//  iord       out  1  0 PC addresses memory, 1 ALUOut
//  irwrite    out  1  load instruction register
//  memwrite   out  1  memory write strobe
//  regdst     out  1  0 rt, 1 rd
//  memtoreg   out  1  0 ALUOut, 1 data register
//  regwrite   out  1  register file write
//  pcen       out  1  PC load = pcwrite | (branch & zero)
//  instr_done out  1  1-cycle pulse on final cycle of each instruction
//  illegal_op out  1  1-cycle pulse in DECODE on unsupported op
// BEHAVIOUR
//  - State register only sequential element; outputs are Moore decode of state, except pcen
//    (uses zero) and wait-gated strobes. Async rst -> state=FETCH immediately.
//  - While rst=1: irwrite, memwrite, regwrite, pcen, instr_done, illegal_op forced 0; other
//    outputs take FETCH values (aluop=00, alusrca=0, alusrcb=01, pcsrc=00, iord=0).
//  - States / outputs (unlisted = 0) / next:
//    FETCH:   iord=0 alusrcb=01 aluop=00 pcsrc=00 irwrite,pcwrite=rdy -> DECODE if rdy else FETCH
//    DECODE:  alusrcb=11 aluop=00 -> lw/sw:MEMADR R(000000):RTYPEEX beq(000100):BEQEX
//             addi(001000):ADDIEX j(000010):JEX; other: illegal_op=1, instr_done=1 -> FETCH
//    MEMADR:  alusrca=1 alusrcb=10 aluop=00 -> lw(100011):MEMRD sw(101011):MEMWR
//    MEMRD:   iord=1 -> MEMWB if rdy else MEMRD
//    MEMWB:   regdst=0 memtoreg=1 regwrite=1 instr_done=1 -> FETCH
//    MEMWR:   iord=1 memwrite=1 (held until rdy) instr_done=rdy -> FETCH if rdy
//    RTYPEEX: alusrca=1 alusrcb=00 aluop=10 -> RTYPEWB
//    RTYPEWB: regdst=1 memtoreg=0 regwrite=1 instr_done=1 -> FETCH
//    BEQEX:   alusrca=1 alusrcb=00 aluop=01 pcsrc=01 branch=1 instr_done=1 -> FETCH
//    ADDIEX:  alusrca=1 alusrcb=10 aluop=00 -> ADDIWB
//    ADDIWB:  regdst=0 memtoreg=0 regwrite=1 instr_done=1 -> FETCH
//    JEX:     pcsrc=10 pcwrite=1 instr_done=1 -> FETCH
//  - rdy = mem_ready when WAIT_EN=1, else constant 1. irwrite/pcwrite in FETCH assert only on
//    the rdy cycle, so a stalled fetch never advances PC or reloads IR.
//  - Latency (WAIT_EN=0): lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2 cycles.
//  - op sampled combinationally each cycle; IR stable after FETCH, so op changes mid-instruction
//    are not the FSM's concern. Unused state encodings -> FETCH next cycle, no strobes.
//  - rst asserted mid-instruction: abandons instruction, no write strobe issued after rst rises.
// TESTING
//  - rst=1 then release, WAIT_EN=0, op=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB;
//    regwrite=1 & memtoreg=1 only in cycle 5; instr_done pulses at cycle 5.
//  - op=000000 -> aluop=10 in RTYPEEX, regdst=1 regwrite=1 next cycle; aluop=00 in all others.
//  - op=000100, zero=1 in BEQEX -> aluop=01, pcsrc=01, pcen=1; repeat zero=0 -> pcen=0.
//  - WAIT_EN=1, op=101011, mem_ready low 3 cycles in MEMWR -> memwrite held 4 cycles, single
//    instr_done on the mem_ready cycle; FETCH with mem_ready low -> irwrite=pcen=0.
//  - op=111111 -> illegal_op=1 in DECODE, back to FETCH, no regwrite/memwrite asserted.
//  - rst pulsed asynchronously during MEMWR -> memwrite drops same cycle, state=FETCH on release.

Source files
------------

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables plus the 2-bit aluop consumed by alu_dec.
module mc_main_ctrl #(
    parameter bit WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] aluop,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       pcen,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    state_t state;
    logic   rdy;

    // With WAIT_EN=0 memory is assumed to complete in one cycle.
    assign rdy = WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   state <= rdy ? DECODE : FETCH;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= RTYPEEX;
                        OP_BEQ:       state <= BEQEX;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JEX;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR: begin
                    if (op == OP_LW)      state <= MEMRD;
                    else if (op == OP_SW) state <= MEMWR;
                    else                  state <= FETCH;
                end
                MEMRD:   state <= rdy ? MEMWB : MEMRD;
                MEMWB:   state <= FETCH;
                MEMWR:   state <= rdy ? FETCH : MEMWR;
                RTYPEEX: state <= RTYPEWB;
                RTYPEWB: state <= FETCH;
                BEQEX:   state <= FETCH;
                ADDIEX:  state <= ADDIWB;
                ADDIWB:  state <= FETCH;
                JEX:     state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    logic pcwrite, branch, irw, mw, rw, done, ill;

    always_comb begin
        aluop    = 2'b00;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        iord     = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        irw      = 1'b0;
        mw       = 1'b0;
        rw       = 1'b0;
        done     = 1'b0;
        ill      = 1'b0;
        case (state)
            FETCH: begin
                alusrcb = 2'b01;
                irw     = rdy;
                pcwrite = rdy;
            end
            DECODE: begin
                alusrcb = 2'b11;
                if (!(op inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J})) begin
                    ill  = 1'b1;
                    done = 1'b1;
                end
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                rw       = 1'b1;
                done     = 1'b1;
            end
            MEMWR: begin
                iord = 1'b1;
                mw   = 1'b1;
                done = rdy;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWB: begin
                regdst = 1'b1;
                rw     = 1'b1;
                done   = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                done    = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: begin
                rw   = 1'b1;
                done = 1'b1;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset holds the state at FETCH asynchronously; only the strobes need explicit masking.
    assign irwrite    = irw  & ~rst;
    assign memwrite   = mw   & ~rst;
    assign regwrite   = rw   & ~rst;
    assign instr_done = done & ~rst;
    assign illegal_op = ill  & ~rst;
    assign pcen       = (pcwrite | (branch & zero)) & ~rst;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: one instance with 1-cycle memory, one waiting on mem_ready.
module tb_mc_main_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, zero0 = 1'b0, mr0 = 1'b0;
    logic [5:0] op0  = 6'd0;
    logic       rst1 = 1'b1, zero1 = 1'b0, mr1 = 1'b0;
    logic [5:0] op1  = 6'd0;

    logic [1:0] aluop0, alusrcb0, pcsrc0, aluop1, alusrcb1, pcsrc1;
    logic alusrca0, iord0, irw0, mw0, rd0, mtr0, rw0, pcen0, done0, ill0;
    logic alusrca1, iord1, irw1, mw1, rd1, mtr1, rw1, pcen1, done1, ill1;

    mc_main_ctrl #(.WAIT_EN(1'b0)) u0 (
        .clk(clk), .rst(rst0), .op(op0), .zero(zero0), .mem_ready(mr0),
        .aluop(aluop0), .alusrca(alusrca0), .alusrcb(alusrcb0), .pcsrc(pcsrc0),
        .iord(iord0), .irwrite(irw0), .memwrite(mw0), .regdst(rd0), .memtoreg(mtr0),
        .regwrite(rw0), .pcen(pcen0), .instr_done(done0), .illegal_op(ill0)
    );

    mc_main_ctrl #(.WAIT_EN(1'b1)) u1 (
        .clk(clk), .rst(rst1), .op(op1), .zero(zero1), .mem_ready(mr1),
        .aluop(aluop1), .alusrca(alusrca1), .alusrcb(alusrcb1), .pcsrc(pcsrc1),
        .iord(iord1), .irwrite(irw1), .memwrite(mw1), .regdst(rd1), .memtoreg(mtr1),
        .regwrite(rw1), .pcen(pcen1), .instr_done(done1), .illegal_op(ill1)
    );

    wire [15:0] out0 = {aluop0, alusrca0, alusrcb0, pcsrc0, iord0, irw0, mw0,
                        rd0, mtr0, rw0, pcen0, done0, ill0};
    wire [15:0] out1 = {aluop1, alusrca1, alusrcb1, pcsrc1, iord1, irw1, mw1,
                        rd1, mtr1, rw1, pcen1, done1, ill1};

    function automatic logic [15:0] mk(
        input logic [1:0] aluop, input logic srca, input logic [1:0] srcb,
        input logic [1:0] pcsrc, input logic iord, input logic irw, input logic mw,
        input logic rd, input logic mtr, input logic rw, input logic pcen,
        input logic done, input logic ill);
        return {aluop, srca, srcb, pcsrc, iord, irw, mw, rd, mtr, rw, pcen, done, ill};
    endfunction

    // Expected output vectors per state, written out from the state table.
    logic [15:0] E_RST, E_FETCH, E_FSTALL, E_DEC, E_DEC_ILL, E_MEMADR, E_MEMRD, E_MEMWB;
    logic [15:0] E_MEMWR_W, E_MEMWR_D, E_REX, E_RWB, E_BEQ_T, E_BEQ_N, E_AEX, E_AWB, E_JEX;
    initial begin
        E_RST     = mk(2'b00,0,2'b01,2'b00,0,0,0,0,0,0,0,0,0);
        E_FETCH   = mk(2'b00,0,2'b01,2'b00,0,1,0,0,0,0,1,0,0);
        E_FSTALL  = mk(2'b00,0,2'b01,2'b00,0,0,0,0,0,0,0,0,0);
        E_DEC     = mk(2'b00,0,2'b11,2'b00,0,0,0,0,0,0,0,0,0);
        E_DEC_ILL = mk(2'b00,0,2'b11,2'b00,0,0,0,0,0,0,0,1,1);
        E_MEMADR  = mk(2'b00,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0);
        E_MEMRD   = mk(2'b00,0,2'b00,2'b00,1,0,0,0,0,0,0,0,0);
        E_MEMWB   = mk(2'b00,0,2'b00,2'b00,0,0,0,0,1,1,0,1,0);
        E_MEMWR_W = mk(2'b00,0,2'b00,2'b00,1,0,1,0,0,0,0,0,0);
        E_MEMWR_D = mk(2'b00,0,2'b00,2'b00,1,0,1,0,0,0,0,1,0);
        E_REX     = mk(2'b10,1,2'b00,2'b00,0,0,0,0,0,0,0,0,0);
        E_RWB     = mk(2'b00,0,2'b00,2'b00,0,0,0,1,0,1,0,1,0);
        E_BEQ_T   = mk(2'b01,1,2'b00,2'b01,0,0,0,0,0,0,1,1,0);
        E_BEQ_N   = mk(2'b01,1,2'b00,2'b01,0,0,0,0,0,0,0,1,0);
        E_AEX     = mk(2'b00,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0);
        E_AWB     = mk(2'b00,0,2'b00,2'b00,0,0,0,0,0,1,0,1,0);
        E_JEX     = mk(2'b00,0,2'b00,2'b10,0,0,0,0,0,0,1,1,0);
    end

    bit          q_sel[$];
    logic [15:0] q_exp[$];
    string       q_nm[$];
    int checks = 0;
    int errors = 0;

    // Push the expectation for the current cycle, then advance to just after the next edge.
    task automatic cyc(input bit sel, input logic [15:0] e, input string nm);
        q_sel.push_back(sel);
        q_exp.push_back(e);
        q_nm.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare on the falling edge, well away from the state update.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            bit          s;
            logic [15:0] e, a;
            string       n;
            s = q_sel.pop_front();
            e = q_exp.pop_front();
            n = q_nm.pop_front();
            a = s ? out1 : out0;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %016b expected %016b", n, a, e);
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        // WAIT_EN=0 instance
        op0 = 6'b100011;
        cyc(0, E_RST, "u0 reset");
        rst0 = 1'b0;
        cyc(0, E_FETCH,  "lw fetch");
        cyc(0, E_DEC,    "lw decode");
        cyc(0, E_MEMADR, "lw memadr");
        cyc(0, E_MEMRD,  "lw memrd");
        cyc(0, E_MEMWB,  "lw memwb");
        op0 = 6'b000000;
        cyc(0, E_FETCH, "r fetch");
        cyc(0, E_DEC,   "r decode");
        cyc(0, E_REX,   "r exec");
        cyc(0, E_RWB,   "r wb");
        op0 = 6'b000100; zero0 = 1'b1;
        cyc(0, E_FETCH, "beq fetch");
        cyc(0, E_DEC,   "beq decode");
        cyc(0, E_BEQ_T, "beq taken");
        zero0 = 1'b0;
        cyc(0, E_FETCH, "beq2 fetch");
        cyc(0, E_DEC,   "beq2 decode");
        cyc(0, E_BEQ_N, "beq not taken");
        op0 = 6'b001000;
        cyc(0, E_FETCH, "addi fetch");
        cyc(0, E_DEC,   "addi decode");
        cyc(0, E_AEX,   "addi exec");
        cyc(0, E_AWB,   "addi wb");
        op0 = 6'b000010;
        cyc(0, E_FETCH, "j fetch");
        cyc(0, E_DEC,   "j decode");
        cyc(0, E_JEX,   "j exec");
        op0 = 6'b111111;
        cyc(0, E_FETCH,   "ill fetch");
        cyc(0, E_DEC_ILL, "ill decode");
        cyc(0, E_FETCH,   "ill back to fetch");

        // WAIT_EN=1 instance
        op1 = 6'b101011; mr1 = 1'b0;
        cyc(1, E_RST, "u1 reset");
        rst1 = 1'b0;
        cyc(1, E_FSTALL, "fetch stall 1");
        cyc(1, E_FSTALL, "fetch stall 2");
        mr1 = 1'b1;
        cyc(1, E_FETCH, "sw fetch");
        mr1 = 1'b0;
        cyc(1, E_DEC,    "sw decode");
        cyc(1, E_MEMADR, "sw memadr");
        for (int i = 0; i < 3; i++) cyc(1, E_MEMWR_W, "sw memwr wait");
        mr1 = 1'b1;
        cyc(1, E_MEMWR_D, "sw memwr done");
        cyc(1, E_FETCH,   "sw2 fetch");
        mr1 = 1'b0;
        cyc(1, E_DEC,     "sw2 decode");
        cyc(1, E_MEMADR,  "sw2 memadr");
        cyc(1, E_MEMWR_W, "sw2 memwr");
        rst1 = 1'b1;
        cyc(1, E_RST, "rst during memwr");
        rst1 = 1'b0;
        cyc(1, E_FSTALL, "fetch after rst");

        @(negedge clk);
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected 0", q_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
